// File: rtl/da_pkg.sv
// Shared types and width helpers for the bit-serial distributed-arithmetic FIR engine.
package da_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUILD,
    ST_COMPUTE
  } da_state_e;

  function automatic int da_lut_w(input int taps, input int coef_w);
    return coef_w + $clog2(taps);
  endfunction

  function automatic int da_out_w(input int lut_w, input int data_w);
    return lut_w + data_w;
  endfunction

  // Six taps, tap 0 in the LSBs: tap0..tap5 = 7, -7, 5, 5, -5, 3
  localparam logic [35:0] DA_DEFAULT_COEFS = {6'd3, 6'h3b, 6'd5, 6'd5, 6'h39, 6'd7};

endpackage

// File: rtl/da_fir_engine_if.sv
// Sample-in / result-out bus of the DA FIR engine; the engine is the slave.
interface da_fir_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 17
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;

  modport master (output in_valid, in_data, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, output in_ready, out_valid, out_data);
endinterface

// File: rtl/da_lut_builder.sv
// Coefficient registers plus a 2^TAPS partial-sum LUT filled one entry per cycle
// while build_en is high; the read port is combinational.
module da_lut_builder
  import da_pkg::*;
#(
  parameter int TAPS   = 6,
  parameter int COEF_W = 6,
  parameter int LUT_W  = da_lut_w(6, 6),
  parameter logic [TAPS*COEF_W-1:0] DEFAULT_COEFS = DA_DEFAULT_COEFS,
  localparam int AW    = $clog2(TAPS),
  localparam int DEPTH = 1 << TAPS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    build_en,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [COEF_W-1:0]       wr_data,
  input  logic [TAPS-1:0]         rd_addr,
  output logic signed [LUT_W-1:0] rd_data,
  output logic                    build_last
);

  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [LUT_W-1:0]  lut_q  [DEPTH];
  logic signed [LUT_W-1:0]  lut_d  [DEPTH];
  logic [TAPS-1:0]          cnt_q, cnt_d;
  logic signed [LUT_W-1:0]  subset_sum;

  // The build counter doubles as the tap-select mask for this entry
  always_comb begin
    subset_sum = '0;
    for (int k = 0; k < TAPS; k++)
      if (cnt_q[k]) subset_sum = subset_sum + LUT_W'(coef_q[k]);
  end

  always_comb begin
    coef_d = coef_q;
    for (int k = 0; k < TAPS; k++)
      if (wr_en && (wr_addr == AW'(k))) coef_d[k] = wr_data;
  end

  // Counter wraps to 0 after the last entry, so a rebuild restarts at address 0
  always_comb begin
    lut_d = lut_q;
    cnt_d = cnt_q;
    if (build_en) begin
      lut_d[cnt_q] = subset_sum;
      cnt_d        = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int k = 0; k < TAPS; k++) coef_q[k] <= DEFAULT_COEFS[k*COEF_W +: COEF_W];
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      coef_q <= coef_d;
      lut_q  <= lut_d;
    end
  end

  assign rd_data    = lut_q[rd_addr];
  assign build_last = build_en && (cnt_q == TAPS'(DEPTH - 1));

endmodule

// File: rtl/da_fir_engine.sv
// Bit-serial DA FIR: FSM, sample delay line and shift-accumulator around da_lut_builder.
// Define DA_COEF_WR_EN to add the runtime coefficient write port.
module da_fir_engine
  import da_pkg::*;
#(
  parameter int TAPS   = 6,
  parameter int DATA_W = 8,
  parameter int COEF_W = 6,
  parameter logic [TAPS*COEF_W-1:0] DEFAULT_COEFS = DA_DEFAULT_COEFS,
  localparam int LUT_W = da_lut_w(TAPS, COEF_W),
  localparam int OUT_W = da_out_w(LUT_W, DATA_W),
  localparam int CA_W  = $clog2(TAPS),
  localparam int BW    = $clog2(DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  da_fir_engine_if.slave   io,
  output logic             busy
`ifdef DA_COEF_WR_EN
  ,
  input  logic             coef_we,
  input  logic [CA_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data
`endif
);

  da_state_e               state_q, state_d;
  logic                    dirty_q, dirty_d;
  logic [DATA_W-1:0]       x_q [TAPS];
  logic [DATA_W-1:0]       x_d [TAPS];
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;

  logic                    wr_hit;
  logic [CA_W-1:0]         wr_addr;
  logic [COEF_W-1:0]       wr_data;
  logic [TAPS-1:0]         lut_addr;
  logic signed [LUT_W-1:0] lut_rd;
  logic                    build_last;
  logic signed [OUT_W-1:0] term;
  logic                    in_ready;
  logic                    last_bit;

`ifdef DA_COEF_WR_EN
  assign wr_hit  = coef_we && (int'(coef_addr) < TAPS);
  assign wr_addr = coef_addr;
  assign wr_data = coef_data;
`else
  assign wr_hit  = 1'b0;
  assign wr_addr = '0;
  assign wr_data = '0;
`endif

  da_lut_builder #(
    .TAPS(TAPS), .COEF_W(COEF_W), .LUT_W(LUT_W), .DEFAULT_COEFS(DEFAULT_COEFS)
  ) u_lut (
    .clk        (clk),
    .rst_n      (rst_n),
    .build_en   (state_q == ST_BUILD),
    .wr_en      (wr_hit),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (lut_addr),
    .rd_data    (lut_rd),
    .build_last (build_last)
  );

  // Bit slice b across all taps selects the partial sum for this bit weight
  always_comb begin
    lut_addr = '0;
    for (int k = 0; k < TAPS; k++) lut_addr[k] = x_q[k][bit_q];
  end

  assign term     = OUT_W'(lut_rd) <<< bit_q;
  assign last_bit = (bit_q == BW'(DATA_W - 1));
  assign in_ready = (state_q == ST_IDLE) && !dirty_q;

  always_comb begin
    state_d     = state_q;
    dirty_d     = dirty_q | wr_hit;
    x_d         = x_q;
    acc_d       = acc_q;
    bit_d       = bit_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    unique case (state_q)
      ST_BUILD: begin
        // Pending or same-cycle write restarts BUILD directly (counter wraps to 0)
        if (build_last) begin
          if (dirty_q || wr_hit) dirty_d = 1'b0;
          else                   state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (io.in_valid && in_ready) begin
          x_d[0] = io.in_data;
          for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
          acc_d   = '0;
          bit_d   = '0;
          state_d = ST_COMPUTE;
        end else if (dirty_q || wr_hit) begin
          dirty_d = 1'b0;
          state_d = ST_BUILD;
        end
      end
      ST_COMPUTE: begin
        // Sign bit of the two's-complement sample carries negative weight
        acc_d = last_bit ? (acc_q - term) : (acc_q + term);
        bit_d = bit_q + 1'b1;
        if (last_bit) begin
          out_data_d  = acc_d;
          out_valid_d = 1'b1;
          bit_d       = '0;
          if (dirty_q || wr_hit) begin
            dirty_d = 1'b0;
            state_d = ST_BUILD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_BUILD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BUILD;
      dirty_q     <= 1'b0;
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      acc_q       <= '0;
      bit_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      bit_q       <= bit_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_da_fir_engine.sv
// Directed bench for da_fir_engine with hand-computed results (default coefs 7,-7,5,5,-5,3).
module tb_da_fir_engine;
  localparam int TAPS = 6, DATA_W = 8, COEF_W = 6, OUT_W = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [5:0]  coef_data = '0;
  int          checks = 0;
  int          failures = 0;

  da_fir_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) io ();

  da_fir_engine #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io),
    .busy  (busy)
`ifdef DA_COEF_WR_EN
    ,
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!io.in_ready && n < 300) begin @(negedge clk); n++; end
    if (!io.in_ready) chk("ready_timeout", 0, 1);
  endtask

  // Called on the first negedge after the accepting edge (latency 1)
  task automatic collect(input string tag, input longint exp, input bit cy, input int lat0);
    int lat = lat0;
    while (!io.out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, lat, 9);
    if (cy) chk({tag, "_y"}, longint'($signed(io.out_data)), exp);
  endtask

  task automatic send(input int d, input longint exp, input string tag,
                      input bit cy = 1'b1, input bit wr = 1'b0,
                      input int wa = 0, input int wd = 0);
    int lat = 1;
    wait_ready();
    io.in_valid = 1'b1;
    io.in_data  = 8'(d);
    @(negedge clk);
    io.in_valid = 1'b0;
    if (wr) begin
      coef_we = 1'b1; coef_addr = 3'(wa); coef_data = 6'(wd);
      @(negedge clk);
      coef_we = 1'b0;
      lat = 2;
    end
    collect(tag, exp, cy, lat);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, pulses;
    logic b_prev;
    longint imp_exp [7] = '{-7, 5, 5, -5, 3, 0, 0};

    io.in_valid = 1'b0;
    io.in_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_data", io.out_data, 0);
    chk("rst_busy", busy, 1);

    // Release with a sample already offered; it must wait for the initial BUILD
    io.in_valid = 1'b1;
    io.in_data  = 8'd1;
    rst_n = 1'b1;
    n = 0;
    b_prev = busy;
    while (!io.in_ready && n < 300) begin b_prev = busy; @(negedge clk); n++; end
    chk("build_cycles", n, 64);
    chk("busy_before_ready", b_prev, 1);
    chk("busy_at_ready", busy, 0);
    @(negedge clk);
    io.in_valid = 1'b0;
    collect("imp0", 7, 1'b1, 1);
    @(negedge clk);
    chk("ov_pulse", io.out_valid, 0);
    chk("out_hold", longint'($signed(io.out_data)), 7);

    for (int i = 0; i < 6; i++) send(0, imp_exp[i], $sformatf("imp%0d", i + 1));

    send(-128, -896, "negfs");
    send(0, 896, "negfs_next");

    for (int i = 0; i < 6; i++) send(127, 1016, "pos_sus", i == 5);
    for (int i = 0; i < 6; i++) send(-128, -1024, "neg_sus", i == 5);

`ifdef DA_COEF_WR_EN
    do_reset();
    send(1, 7, "wr_mid", 1'b1, 1'b1, 0, -32);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    chk("rebuild_busy", n, 64);
    for (int i = 0; i < 6; i++) send(0, imp_exp[i], $sformatf("wr_flush%0d", i));
    send(1, -32, "wr_new_imp");
    coef_we = 1'b1; coef_addr = 3'd6; coef_data = 6'd1;
    @(negedge clk);
    coef_we = 1'b0;
    chk("bad_addr_ready", io.in_ready, 1);
    @(negedge clk);
    chk("bad_addr_busy", busy, 0);
`endif

    // Abort a COMPUTE with reset; the line holds nonzero samples beforehand
    do_reset();
    send(127, 889, "pre_a");
    send(127, 0, "pre_b", 1'b0);
    wait_ready();
    io.in_valid = 1'b1;
    io.in_data  = 8'd100;
    @(negedge clk);
    io.in_valid = 1'b0;
    @(negedge clk);
    rst_n  = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge clk); pulses += int'(io.out_valid); end
    chk("abort_out_data", io.out_data, 0);
    chk("abort_in_ready", io.in_ready, 0);
    chk("abort_busy", busy, 1);
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); pulses += int'(io.out_valid); end
    chk("abort_no_valid", pulses, 0);
    send(1, 7, "post_abort_imp");
    send(0, -7, "post_abort_imp1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
